// File: rtl/filter_gauss_5x5.sv
// 5x5 binomial blur / unsharp mask stage on a 25-tap window from filter_core_5x5.
// Latency: fixed 3 clk from taps and de/hs/vs to do_o/de_o/hs_o/vs_o.
// Backpressure: none; the pipeline advances every clk regardless of de_i.
module filter_gauss_5x5 #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bypass,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] x1,
  input  logic [DATA_WIDTH-1:0] x2,
  input  logic [DATA_WIDTH-1:0] x3,
  input  logic [DATA_WIDTH-1:0] x4,
  input  logic [DATA_WIDTH-1:0] x5,
  input  logic [DATA_WIDTH-1:0] x6,
  input  logic [DATA_WIDTH-1:0] x7,
  input  logic [DATA_WIDTH-1:0] x8,
  input  logic [DATA_WIDTH-1:0] x9,
  input  logic [DATA_WIDTH-1:0] xA,
  input  logic [DATA_WIDTH-1:0] xB,
  input  logic [DATA_WIDTH-1:0] xC,
  input  logic [DATA_WIDTH-1:0] xD,
  input  logic [DATA_WIDTH-1:0] xE,
  input  logic [DATA_WIDTH-1:0] xF,
  input  logic [DATA_WIDTH-1:0] xG,
  input  logic [DATA_WIDTH-1:0] xH,
  input  logic [DATA_WIDTH-1:0] xI,
  input  logic [DATA_WIDTH-1:0] xJ,
  input  logic [DATA_WIDTH-1:0] xK,
  input  logic [DATA_WIDTH-1:0] xL,
  input  logic [DATA_WIDTH-1:0] xM,
  input  logic [DATA_WIDTH-1:0] xN,
  input  logic [DATA_WIDTH-1:0] xO,
  input  logic [DATA_WIDTH-1:0] xP,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  localparam int DW = DATA_WIDTH;
  localparam int HW = DW + 4;  // row sum: weights 1+4+6+4+1 = 16
  localparam int VW = DW + 8;  // full 2-D sum: weights total 256

  // Window taps, row-major; index 12 is the centre tap xD
  logic [DW-1:0] tap [25];
  assign tap[0]  = x1; assign tap[1]  = x2; assign tap[2]  = x3; assign tap[3]  = x4; assign tap[4]  = x5;
  assign tap[5]  = x6; assign tap[6]  = x7; assign tap[7]  = x8; assign tap[8]  = x9; assign tap[9]  = xA;
  assign tap[10] = xB; assign tap[11] = xC; assign tap[12] = xD; assign tap[13] = xE; assign tap[14] = xF;
  assign tap[15] = xG; assign tap[16] = xH; assign tap[17] = xI; assign tap[18] = xJ; assign tap[19] = xK;
  assign tap[20] = xL; assign tap[21] = xM; assign tap[22] = xN; assign tap[23] = xO; assign tap[24] = xP;

  // Frame-stable control: only updated during vertical blanking
  logic          mode_r_q, mode_r_d;
  logic          bypass_r_q, bypass_r_d;
  // S1: horizontal row sums plus centre tap and the control that applies to this pixel
  logic [HW-1:0] h_q [5];
  logic [HW-1:0] h_d [5];
  logic [DW-1:0] xd1_q, xd1_d;
  logic          md1_q, md1_d, bp1_q, bp1_d;
  // S2: vertical sum
  logic [VW-1:0] v_q, v_d;
  logic [DW-1:0] xd2_q, xd2_d;
  logic          md2_q, md2_d, bp2_q, bp2_d;
  // S3: output pixel
  logic [DW-1:0] do_q, do_d;
  // Sync delay lines
  logic [2:0]    de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  // Blur intermediates for the output stage
  logic [DW-1:0]        g;
  logic signed [DW+1:0] u;

  // S1/S2 separable filter arithmetic and control capture
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      h_d[r] = HW'(tap[5*r]) + (HW'(tap[5*r+1]) << 2) + (HW'(tap[5*r+2]) << 2)
             + (HW'(tap[5*r+2]) << 1) + (HW'(tap[5*r+3]) << 2) + HW'(tap[5*r+4]);
    end
    v_d = VW'(h_q[0]) + (VW'(h_q[1]) << 2) + (VW'(h_q[2]) << 2)
        + (VW'(h_q[2]) << 1) + (VW'(h_q[3]) << 2) + VW'(h_q[4]);
    xd1_d = tap[12];
    xd2_d = xd1_q;
    // A pixel uses the control latched before it entered, so the whole frame is uniform
    md1_d = mode_r_q;
    bp1_d = bypass_r_q;
    md2_d = md1_q;
    bp2_d = bp1_q;
    mode_r_d   = vs_i ? mode_r_q   : mode;
    bypass_r_d = vs_i ? bypass_r_q : bypass;
    de_d = {de_q[1:0], de_i};
    hs_d = {hs_q[1:0], hs_i};
    vs_d = {vs_q[1:0], vs_i};
  end

  // S3: round the blur, optionally sharpen with clamping, or pass the centre tap
  always_comb begin
    g = DW'((v_q + VW'(128)) >> 8);
    u = $signed({1'b0, xd2_q, 1'b0}) - $signed({2'b00, g});
    if (bp2_q)       do_d = xd2_q;
    else if (!md2_q) do_d = g;
    else if (u[DW+1]) do_d = '0;
    else if (u[DW])   do_d = '1;
    else              do_d = u[DW-1:0];
  end

  // Pipeline registers; hs idles high, everything else clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r_q   <= 1'b0;
      bypass_r_q <= 1'b0;
      for (int r = 0; r < 5; r++) h_q[r] <= '0;
      xd1_q <= '0;
      md1_q <= 1'b0;
      bp1_q <= 1'b0;
      v_q   <= '0;
      xd2_q <= '0;
      md2_q <= 1'b0;
      bp2_q <= 1'b0;
      do_q  <= '0;
      de_q  <= '0;
      hs_q  <= '1;
      vs_q  <= '0;
    end else begin
      mode_r_q   <= mode_r_d;
      bypass_r_q <= bypass_r_d;
      h_q   <= h_d;
      xd1_q <= xd1_d;
      md1_q <= md1_d;
      bp1_q <= bp1_d;
      v_q   <= v_d;
      xd2_q <= xd2_d;
      md2_q <= md2_d;
      bp2_q <= bp2_d;
      do_q  <= do_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign do_o = do_q;
  assign de_o = de_q[2];
  assign hs_o = hs_q[2];
  assign vs_o = vs_q[2];

endmodule

// File: tb/tb_filter_gauss_5x5.sv
// Bench for filter_gauss_5x5: 12-bit and 8-bit instances driven from one window.
// Outputs compared each falling edge against a 3-cycle-delayed reference.
// No backpressure on the block; stimulus runs open-loop.
module tb_filter_gauss_5x5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, bypass, mode, de_i, hs_i, vs_i;
  logic [11:0] tv  [25];
  logic [7:0]  tv8 [25];
  logic [11:0] do_o;
  logic        de_o, hs_o, vs_o;
  logic [7:0]  do8;
  logic        de8, hs8, vs8;

  int cur [25];
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  filter_gauss_5x5 #(.DATA_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .bypass(bypass), .mode(mode),
    .x1(tv[0]),   .x2(tv[1]),   .x3(tv[2]),   .x4(tv[3]),   .x5(tv[4]),
    .x6(tv[5]),   .x7(tv[6]),   .x8(tv[7]),   .x9(tv[8]),   .xA(tv[9]),
    .xB(tv[10]),  .xC(tv[11]),  .xD(tv[12]),  .xE(tv[13]),  .xF(tv[14]),
    .xG(tv[15]),  .xH(tv[16]),  .xI(tv[17]),  .xJ(tv[18]),  .xK(tv[19]),
    .xL(tv[20]),  .xM(tv[21]),  .xN(tv[22]),  .xO(tv[23]),  .xP(tv[24]),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  filter_gauss_5x5 #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bypass(bypass), .mode(mode),
    .x1(tv8[0]),  .x2(tv8[1]),  .x3(tv8[2]),  .x4(tv8[3]),  .x5(tv8[4]),
    .x6(tv8[5]),  .x7(tv8[6]),  .x8(tv8[7]),  .x9(tv8[8]),  .xA(tv8[9]),
    .xB(tv8[10]), .xC(tv8[11]), .xD(tv8[12]), .xE(tv8[13]), .xF(tv8[14]),
    .xG(tv8[15]), .xH(tv8[16]), .xI(tv8[17]), .xJ(tv8[18]), .xK(tv8[19]),
    .xL(tv8[20]), .xM(tv8[21]), .xN(tv8[22]), .xO(tv8[23]), .xP(tv8[24]),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do8), .de_o(de8), .hs_o(hs8), .vs_o(vs8)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: direct 2-D weighted sum with the binomial kernel
  function automatic int ref_pix(input int t[25], input bit md, input bit bp, input int maxv);
    int k[5] = '{1, 4, 6, 4, 1};
    int acc, g, u;
    acc = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        acc += k[r] * k[c] * t[5*r+c];
    g = (acc + 128) / 256;
    if (bp) return t[12];
    if (!md) return g;
    u = 2 * t[12] - g;
    if (u < 0) return 0;
    if (u > maxv) return maxv;
    return u;
  endfunction

  typedef struct { int d12; int d8; bit de; bit hs; bit vs; } exp_t;
  exp_t hist [3];
  exp_t e_new;
  bit   mdl_mode, mdl_byp;
  int   t8 [25];

  // Reference timeline: each sampled input becomes visible three edges later
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '{d12: 0, d8: 0, de: 1'b0, hs: 1'b1, vs: 1'b0};
      mdl_mode = 1'b0;
      mdl_byp  = 1'b0;
    end else begin
      for (int i = 0; i < 25; i++) t8[i] = cur[i] & 255;
      e_new.d12 = ref_pix(cur, mdl_mode, mdl_byp, 4095);
      e_new.d8  = ref_pix(t8, mdl_mode, mdl_byp, 255);
      e_new.de  = de_i;
      e_new.hs  = hs_i;
      e_new.vs  = vs_i;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e_new;
      if (!vs_i) begin
        mdl_mode = mode;
        mdl_byp  = bypass;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        chk("rst_do", do_o, 0);
        chk("rst_de", de_o, 0);
        chk("rst_hs", hs_o, 1);
        chk("rst_vs", vs_o, 0);
      end else begin
        chk("de", de_o, hist[2].de);
        chk("hs", hs_o, hist[2].hs);
        chk("vs", vs_o, hist[2].vs);
        chk("de8", de8, hist[2].de);
        if (hist[2].de) begin
          chk("do12", do_o, hist[2].d12);
          chk("do8", do8, hist[2].d8);
        end
      end
    end
  end

  task automatic put(input int i, input int v);
    cur[i] = v;
    tv[i]  = v[11:0];
    tv8[i] = v[7:0];
  endtask

  task automatic set_imp(input int centre, input int other);
    for (int i = 0; i < 25; i++) put(i, (i == 12) ? centre : other);
  endtask

  task automatic set_rand(input int kind);
    int f;
    f = $urandom_range(4095);
    for (int i = 0; i < 25; i++) begin
      case (kind)
        0: put(i, $urandom_range(4095));
        1: put(i, (i == 12) ? $urandom_range(4095, 3000) : $urandom_range(200));
        2: put(i, (i == 12) ? $urandom_range(100) : $urandom_range(4095, 3500));
        3: put(i, f);
        4: put(i, $urandom_range(255));
        default: put(i, (i == 12) ? $urandom_range(255, 200) : $urandom_range(20));
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n, input bit md, input bit bp);
    vs_i = 1'b0; de_i = 1'b0; hs_i = 1'b1; mode = md; bypass = bp;
    repeat (n) tick();
  endtask

  // One active pixel of a fresh frame, then read it back after the pipeline delay
  task automatic direct(input string tag, input bit md, input bit bp, input int exp12, input int exp8);
    blank(2, md, bp);
    vs_i = 1'b1; de_i = 1'b1;
    tick();
    de_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk({tag, "_12"}, do_o, exp12);
    chk({tag, "_8"}, do8, exp8);
    #1;
  endtask

  task automatic line(input int w, input bit wiggle);
    vs_i = 1'b1; de_i = 1'b0;
    hs_i = 1'b0; tick(); tick();
    hs_i = 1'b1; tick(); tick();
    de_i = 1'b1;
    for (int p = 0; p < w; p++) begin
      set_rand($urandom_range(5));
      if (wiggle) begin
        mode   = $urandom_range(1);
        bypass = ($urandom_range(7) == 0);
      end
      tick();
    end
    de_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; mode = 1'b0; bypass = 1'b0;
    de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
    set_imp(0, 0);
    chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    set_imp(100, 100);   direct("flat100", 1'b0, 1'b0, 100, 100);
    set_imp(4095, 4095); direct("flatmax", 1'b0, 1'b0, 4095, 255);
    set_imp(255, 0);     direct("imp_blur", 1'b0, 1'b0, 36, 36);
    set_imp(255, 0);     direct("imp_sharp", 1'b1, 1'b0, 474, 255);
    set_imp(0, 255);     direct("inv_blur", 1'b0, 1'b0, 219, 219);
    set_imp(0, 255);     direct("inv_sharp", 1'b1, 1'b0, 0, 0);
    set_imp(2000, 7);    direct("bypass", 1'b1, 1'b1, 2000, 208);

    // Mode raised mid-frame must not affect the current frame
    blank(2, 1'b0, 1'b0);
    vs_i = 1'b1;
    tick(); tick();
    mode = 1'b1;
    set_imp(255, 0);
    de_i = 1'b1;
    tick();
    de_i = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("mode_frozen", do_o, 36);
    #1;
    direct("mode_next_frame", 1'b1, 1'b0, 474, 255);

    // Reset pulse in the middle of an active line
    blank(2, 1'b1, 1'b0);
    vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b1;
    for (int i = 0; i < 6; i++) begin set_rand(0); tick(); end
    rst = 1'b0;
    #1;
    chk("arst_do", do_o, 0);
    chk("arst_de", de_o, 0);
    chk("arst_hs", hs_o, 1);
    chk("arst_vs", vs_o, 0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_rand(0);
      @(negedge clk);
      chk("de_after_rst", de_o, (i == 3) ? 1 : 0);
      tick();
    end
    de_i = 1'b0;

    // Randomized frames with per-frame mode/bypass and ignored mid-frame changes
    for (int f = 0; f < 14; f++) begin
      blank(4, $urandom_range(1), ($urandom_range(3) == 0));
      for (int l = 0; l < 4; l++) line(16, 1'b1);
    end
    blank(6, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
